// File: rtl/seg7_scan_display_if.sv
// Display-side bundle between the counter stage and the 7-segment driver.
//   Value : binary count into the driver (VALUE_W bits)
//   Seg/Dp/An : active-low segment, decimal-point and anode pins; Busy : conversion running
// master = counter/board side, slave = the driver itself.
interface seg7_scan_display_if #(
   parameter int VALUE_W = 4
);
   logic [VALUE_W-1:0] Value;
   logic [6:0]         Seg;
   logic               Dp;
   logic [3:0]         An;
   logic               Busy;

   modport master (output Value, input Seg, Dp, An, Busy);
   modport slave  (input Value, output Seg, Dp, An, Busy);
endinterface

// File: rtl/seg7_scan_display.sv
// Binary-to-decimal 4-digit multiplexed 7-segment driver (double-dabble + digit scan).
// Latency: Value capture edge to display register is VALUE_W+2 cycles; Seg/An registered.
// Backpressure: none; Value is sampled only at each IDLE capture, later changes wait a pass.
// Ports: Clk (rising edge), Reset (async, active-low), disp (slave modport):
//   disp.Value in, disp.Seg/Dp/An out (active-low), disp.Busy out (high during SHIFT).
module seg7_scan_display #(
   parameter int VALUE_W     = 4,
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic               Clk,
   input  logic               Reset,
   seg7_scan_display_if.slave disp
);
   localparam int CNT_W = $clog2(VALUE_W + 1);
   localparam int DIV_W = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

   state_t             r_state, w_state_nxt;
   logic [VALUE_W-1:0] r_shift, w_shift_nxt;
   logic [15:0]        r_scratch, w_scratch_nxt;
   logic [15:0]        w_adj;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [15:0]        r_bcd, w_bcd_nxt;
   logic [DIV_W-1:0]   r_div;
   logic [1:0]         r_idx, w_idx_nxt;
   logic               w_wrap;
   logic [3:0]         w_nib;
   logic               w_lz;
   logic [6:0]         r_seg, w_seg_nxt;
   logic [3:0]         r_an;

   function automatic logic [6:0] f_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;   // >9 cannot come out of the converter; show blank
      endcase
      return s;
   endfunction

   // Double-dabble pre-shift correction, each nibble independently (no inter-nibble carry).
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 4; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_cnt_nxt     = r_cnt;
      w_bcd_nxt     = r_bcd;
      case (r_state)
         S_IDLE: begin
            w_shift_nxt   = disp.Value;
            w_scratch_nxt = '0;
            w_cnt_nxt     = CNT_W'(VALUE_W);
            w_state_nxt   = S_SHIFT;
         end
         S_SHIFT: begin
            {w_scratch_nxt, w_shift_nxt} = {w_adj, r_shift} << 1;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_bcd_nxt   = r_scratch;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_wrap    = (r_div == DIV_W'(REFRESH_DIV - 1));
   assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

   // Seg is decoded from next-cycle display data and digit so that a LOAD and a
   // digit advance landing on the same edge both show up together.
   assign w_nib = w_bcd_nxt[4*w_idx_nxt +: 4];

   always_comb begin
      w_lz = 1'b0;
      case (w_idx_nxt)
         2'd1:    w_lz = (w_bcd_nxt[15:4]  == 12'd0);
         2'd2:    w_lz = (w_bcd_nxt[15:8]  == 8'd0);
         2'd3:    w_lz = (w_bcd_nxt[15:12] == 4'd0);
         default: w_lz = 1'b0;
      endcase
      w_seg_nxt = (BLANK_LZ && w_lz) ? 7'h7F : f_seg(w_nib);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_bcd     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bcd     <= w_bcd_nxt;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_div <= '0;
         r_idx <= 2'd0;
         r_seg <= 7'h40;
         r_an  <= 4'b1110;
      end else begin
         r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
         r_idx <= w_idx_nxt;
         r_seg <= w_seg_nxt;
         r_an  <= ~(4'b0001 << w_idx_nxt);
      end
   end

   assign disp.Seg  = r_seg;
   assign disp.An   = r_an;
   assign disp.Dp   = 1'b1;
   assign disp.Busy = (r_state == S_SHIFT);
endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: three instances (W=4/RD=2/blank, W=13/RD=4/blank,
// W=4/RD=2/no-blank) compared every cycle against a decimal-arithmetic model.
module tb_seg7_scan_display;
   localparam int W_T   [3] = '{4, 13, 4};
   localparam int RD_T  [3] = '{2, 4, 2};
   localparam int BLZ_T [3] = '{1, 1, 0};

   logic Clk;
   logic Reset;
   int   vals [3];
   int   n;
   int   cap  [3];
   int   dispv[3];
   int   n_chk;
   int   n_pass;

   logic [6:0] seg_o [3];
   logic [3:0] an_o  [3];
   logic       dp_o  [3];
   logic       busy_o[3];

   seg7_scan_display_if #(.VALUE_W(4))  if_a ();
   seg7_scan_display_if #(.VALUE_W(13)) if_b ();
   seg7_scan_display_if #(.VALUE_W(4))  if_c ();

   seg7_scan_display #(.VALUE_W(4),  .REFRESH_DIV(2), .BLANK_LZ(1'b1)) dut_a (.Clk(Clk), .Reset(Reset), .disp(if_a));
   seg7_scan_display #(.VALUE_W(13), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (.Clk(Clk), .Reset(Reset), .disp(if_b));
   seg7_scan_display #(.VALUE_W(4),  .REFRESH_DIV(2), .BLANK_LZ(1'b0)) dut_c (.Clk(Clk), .Reset(Reset), .disp(if_c));

   assign if_a.Value = 4'(vals[0]);
   assign if_b.Value = 13'(vals[1]);
   assign if_c.Value = 4'(vals[2]);

   assign seg_o[0] = if_a.Seg;  assign an_o[0] = if_a.An;  assign dp_o[0] = if_a.Dp;  assign busy_o[0] = if_a.Busy;
   assign seg_o[1] = if_b.Seg;  assign an_o[1] = if_b.An;  assign dp_o[1] = if_b.Dp;  assign busy_o[1] = if_b.Busy;
   assign seg_o[2] = if_c.Seg;  assign an_o[2] = if_c.An;  assign dp_o[2] = if_c.Dp;  assign busy_o[2] = if_c.Busy;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
   endtask

   function automatic int pw10(input int k);
      case (k)
         0: return 1;
         1: return 10;
         2: return 100;
         default: return 1000;
      endcase
   endfunction

   function automatic int digit_seg(input int d);
      case (d)
         0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;  4: return 'h19;
         5: return 'h12;  6: return 'h02;  7: return 'h78;  8: return 'h00;  default: return 'h10;
      endcase
   endfunction

   // Expected Seg for decimal value v shown at digit position idx.
   function automatic int exp_seg(input int v, input int idx, input int blz);
      if (blz != 0 && idx > 0 && v < pw10(idx)) return 'h7F;
      return digit_seg((v / pw10(idx)) % 10);
   endfunction

   // Model: n is the number of clock edges since reset release (-1 = none yet).
   // A conversion pass is W+2 edges long: capture at n%P==0, display load at n%P==W+1.
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         n = -1;
         for (int i = 0; i < 3; i++) begin
            cap[i]   = 0;
            dispv[i] = 0;
         end
      end else begin
         n = n + 1;
         for (int i = 0; i < 3; i++) begin
            if (n % (W_T[i] + 2) == 0)         cap[i]   = vals[i];
            if (n % (W_T[i] + 2) == W_T[i] + 1) dispv[i] = cap[i];
         end
      end
   end

   // Per-cycle comparison of every instance against the model.
   always @(negedge Clk) begin : cmp
      int idx;
      int busy_e;
      for (int i = 0; i < 3; i++) begin
         idx    = (n < 0) ? 0 : ((n + 1) / RD_T[i]) % 4;
         busy_e = (n >= 0 && (n % (W_T[i] + 2)) < W_T[i]) ? 1 : 0;
         chk($sformatf("an%0d", i),   an_o[i],   int'(~(4'b0001 << idx) & 4'hF));
         chk($sformatf("seg%0d", i),  seg_o[i],  exp_seg(dispv[i], idx, BLZ_T[i]));
         chk($sformatf("busy%0d", i), busy_o[i], busy_e);
         chk($sformatf("dp%0d", i),   dp_o[i],   1);
      end
      chk("onehot_a", $countones(~an_o[0]), 1);
   end

   task automatic wait_n(input int tgt);
      for (int k = 0; k < 300; k++) begin
         if (n == tgt) return;
         @(negedge Clk);
      end
      chk($sformatf("timeout_n%0d", tgt), n, tgt);
   endtask

   task automatic do_reset(input int va, input int vb, input int vc);
      @(posedge Clk);
      #2 Reset = 1'b0;
      vals[0] = va;
      vals[1] = vb;
      vals[2] = vc;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      n      = -1;
      Reset  = 1'b0;
      vals[0] = 7;
      vals[1] = 8191;
      vals[2] = 0;
      repeat (5) @(negedge Clk);
      chk("rst_an",   an_o[0],   'hE);
      chk("rst_seg",  seg_o[0],  'h40);
      chk("rst_dp",   dp_o[0],   1);
      chk("rst_busy", busy_o[0], 0);
      Reset = 1'b1;

      // Value 7 on A, 8191 on B, 0 on C with and without blanking.
      wait_n(0);  chk("A_busy_n0", busy_o[0], 1);
      wait_n(3);  chk("A_seg_lz_n3", seg_o[0], 'h7F);
                  chk("C_an_n3", an_o[2], 'hB);
                  chk("C_seg_n3", seg_o[2], 'h40);
      wait_n(4);  chk("A_busy_n4", busy_o[0], 0);
      wait_n(7);  chk("A_seg7_n7", seg_o[0], 'h78);
                  chk("A_an_n7", an_o[0], 'hE);
      wait_n(15); chk("B_seg_d0", seg_o[1], 'h79);  chk("B_an_d0", an_o[1], 'hE);
      wait_n(19); chk("B_seg_d1", seg_o[1], 'h10);  chk("B_an_d1", an_o[1], 'hD);
      wait_n(23); chk("B_seg_d2", seg_o[1], 'h79);  chk("B_an_d2", an_o[1], 'hB);
      wait_n(27); chk("B_seg_d3", seg_o[1], 'h00);  chk("B_an_d3", an_o[1], 'h7);

      // Value 3 changed to 12 right after the capture edge.
      do_reset(3, 8191, 0);
      wait_n(0);  vals[0] = 12;
      wait_n(7);  chk("A_seg3_n7", seg_o[0], 'h30);
      wait_n(15); chk("A_seg12_d0", seg_o[0], 'h24);
      wait_n(17); chk("A_seg12_d1", seg_o[0], 'h79);  chk("A_an12_d1", an_o[0], 'hD);

      // Asynchronous reset in the middle of a conversion.
      wait_n(20);
      vals[0] = 15;
      @(posedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("async_an",   an_o[0],   'hE);
      chk("async_seg",  seg_o[0],  'h40);
      chk("async_busy", busy_o[0], 0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      wait_n(7);  chk("A_seg15_d0", seg_o[0], 'h12);
      wait_n(9);  chk("A_seg15_d1", seg_o[0], 'h79);

      // Random Value sequences, values change on any cycle.
      do_reset(int'($urandom_range(0, 15)), int'($urandom_range(0, 8191)), int'($urandom_range(0, 15)));
      repeat (1000) begin
         @(negedge Clk);
         vals[0] = int'($urandom_range(0, 15));
         vals[1] = int'($urandom_range(0, 8191));
         vals[2] = int'($urandom_range(0, 15));
      end
      @(negedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the lab counter stage: takes a binary count value and shows it in decimal on a 4-digit common-anode 7-segment display.
- A sequential double-dabble engine converts the binary value to BCD, one shift per cycle.
- A refresh divider and digit-scan sequencer time-multiplex the four digits.
- Sits between the counter and the board display pins.

Parameters:
VALUE_W, 4, width of the binary input; legal range 1..13, so the maximum value 8191 fits in 4 BCD digits.
REFRESH_DIV, 50000, Clk cycles each digit stays enabled; legal values >= 2.
BLANK_LZ, 1, 1 = blank leading-zero digits; 0 = show all four digits.

Ports:
Clk  input  1  rising-edge system clock.
Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Value  input  VALUE_W  binary value to display, driven by the counter stage.
Seg  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
Dp  output  1  decimal point, active-low; held 1 (off) at all times.
An  output  4  digit anodes, active-low, one-hot; An[0] is the ones digit.
Busy  output  1  1 while a conversion is in progress.

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - conversion FSM = IDLE, Busy=0, BCD display register = 0000;
  - divider = 0, digit index = 0;
  - outputs An=4'b1110, Seg=7'h40 (digit "0"), Dp=1.
  - Outputs hold these values while Reset stays low. Release takes effect on the next rising Clk edge.
- Conversion FSM, free-running, with states IDLE, SHIFT and LOAD:
  - IDLE: capture Value into the shift register, clear the BCD scratch register, set the iteration counter to VALUE_W, go to SHIFT. Busy=1 from the next cycle.
  - SHIFT (VALUE_W cycles): in each cycle, every scratch nibble >= 5 gets +3. The combined {scratch, shift register} then shifts left by 1. Decrement the counter; go to LOAD when it reaches 0.
  - LOAD (1 cycle): copy the scratch register to the display register; Busy=0; go to IDLE.
  - Latency from the Value capture edge to the display register update is VALUE_W+2 cycles.
  - Worst-case latency from a Value change to display is 2*(VALUE_W+2) cycles.
  - Value changes during SHIFT/LOAD are ignored until the next IDLE capture. No tearing: the display register only changes in LOAD.
  - Width rules: the scratch register is 16 bits; +3 adjustment applies per nibble with no carry between nibbles.
- Scan sequencer:
  - Divider counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, the digit index advances 0→1→2→3→0.
  - An and Seg are registered and change on the same edge. There is no cycle with two anodes active.
- Segment decode (hex of Seg):
  - digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10;
  - blank = 7F;
  - any nibble > 9 decodes to blank (unreachable, defensive).
- Leading-zero blanking (BLANK_LZ=1):
  - digit k (k>=1) is blanked when it and all higher digits are 0;
  - digit 0 is never blanked, so 0 displays as "0";
  - a blanked digit keeps its anode active with Seg=7F, so scan timing is unchanged.
- Simultaneous events: a display-register update and a digit advance on the same edge are legal. Seg reflects the new display register from that edge onward.
- Reset asserted mid-SHIFT aborts the conversion. After release, the FSM restarts from IDLE and the display reads 0 until the first LOAD.

Test Plan:
1. Hold Reset=0 for 5 cycles, then release → during reset An=1110, Seg=40, Dp=1, Busy=0. With Value=7: Busy=1 on cycle 2 after release; display register=0007 after VALUE_W+2=6 cycles; Seg=78 on digit 0; digits 1-3 show Seg=7F.
2. VALUE_W=13, Value=8191, REFRESH_DIV=4 → after 15 cycles the display register = 8191. Scan over 16 cycles gives, in order: An=1110 Seg=79, An=1101 Seg=10, An=1011 Seg=79, An=0111 Seg=00, each held 4 cycles.
3. VALUE_W=4, BLANK_LZ=0, Value=0 → all four digits show Seg=40. Repeat with BLANK_LZ=1 → only An[0] shows 40; the others show 7F.
4. Change Value 3→12 on the cycle after IDLE capture → the display shows 3 at the first LOAD. It shows 12 (digit0 Seg=24, digit1 Seg=79) within 2*(VALUE_W+2)=12 cycles, never any other value.
5. Assert Reset mid-SHIFT with Value=15 → An=1110 and Seg=40 immediately, without waiting for a Clk edge, and the display register = 0. After release, the display shows 15 after 6 cycles.
6. Run 1000 cycles with a random Value sequence → exactly one An bit is low every cycle, and the displayed BCD always equals some previously captured Value.
